// File: rtl/fsm.sv
// rtl/fsm.sv - garage-door motor controller FSM; optional FAULT state under FSM_FAULT_EN
// Motor enables are Mealy outputs decoded from next state and forced low while RST is high.
module fsm (
    input  logic CLK,
    input  logic RST,
    input  logic Activate,
    input  logic Up_Max,
    input  logic Down_Max,
    output logic Up_Motor,
    output logic Down_Motor
);

`ifdef FSM_FAULT_EN
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MV_UP = 2'b01,
        MV_DN = 2'b10,
        FAULT = 2'b11
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        MV_UP = 2'b01,
        MV_DN = 2'b10
    } state_t;
`endif

    state_t r_state;
    state_t w_next_state;
    logic   w_limit_conflict;

    assign w_limit_conflict = Up_Max && Down_Max;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE: begin
                // Mid-travel activation opens the door toward the safe position.
                if (!Activate)                   w_next_state = IDLE;
                else if (Up_Max && !Down_Max)    w_next_state = MV_DN;
                else if (Down_Max && !Up_Max)    w_next_state = MV_UP;
                else if (w_limit_conflict)       w_next_state = IDLE;
                else                             w_next_state = MV_UP;
            end
            MV_UP: w_next_state = Up_Max   ? IDLE : MV_UP;
            MV_DN: w_next_state = Down_Max ? IDLE : MV_DN;
`ifdef FSM_FAULT_EN
            FAULT: w_next_state = w_limit_conflict ? FAULT : IDLE;
`endif
            default: w_next_state = IDLE;
        endcase
`ifdef FSM_FAULT_EN
        if (w_limit_conflict) begin
            w_next_state = FAULT;
        end
`endif
    end

    assign Up_Motor   = !RST && (w_next_state == MV_UP);
    assign Down_Motor = !RST && (w_next_state == MV_DN);

endmodule

// File: tb/tb_fsm.sv
// tb/tb_fsm.sv - directed self-checking bench for the garage-door FSM
module tb_fsm;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic Activate = 1'b0;
    logic Up_Max = 1'b0;
    logic Down_Max = 1'b0;
    logic Up_Motor;
    logic Down_Motor;

    int total = 0;
    int bad = 0;

    fsm dut (
        .CLK(CLK),
        .RST(RST),
        .Activate(Activate),
        .Up_Max(Up_Max),
        .Down_Max(Down_Max),
        .Up_Motor(Up_Motor),
        .Down_Motor(Down_Motor)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic exp_up, input logic exp_dn);
        total++;
        assert (Up_Motor === exp_up && Down_Motor === exp_dn) else begin
            bad++;
            $error("FAIL %s: observed up=%b dn=%b expected up=%b dn=%b",
                   tag, Up_Motor, Down_Motor, exp_up, exp_dn);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive(input logic act, input logic up, input logic dn);
        Activate = act;
        Up_Max   = up;
        Down_Max = dn;
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1);
        #1;
        check("reset_outputs_low", 1'b0, 1'b0);
        tick();
        check("reset_held_across_edge", 1'b0, 1'b0);

        RST = 1'b0;
        #1;
        tick();
        check("open_after_reset_edge", 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("mv_up_holds_off_bottom", 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("mv_up_ignores_activate", 1'b1, 1'b0);

        drive(1'b1, 1'b1, 1'b0);
        check("up_limit_stops_same_cycle", 1'b0, 1'b0);
        tick();
        check("idle_at_top_requests_down", 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("mv_dn_reached", 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0);
        check("mv_dn_ignores_up_limit", 1'b0, 1'b1);

        drive(1'b1, 1'b1, 1'b1);
        check("conflict_in_mv_dn", 1'b0, 1'b0);
        tick();
        check("conflict_after_edge", 1'b0, 1'b0);
        tick();
        check("conflict_held", 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        tick();
        check("no_activate_both_limits", 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("idle_after_conflict_clears", 1'b0, 1'b0);
        tick();
        check("idle_stays_idle", 1'b0, 1'b0);

        drive(1'b1, 1'b0, 1'b1);
        check("idle_at_bottom_requests_up", 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("mid_travel_opens", 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0);
        check("mv_up_from_mid_travel", 1'b1, 1'b0);

        RST = 1'b1;
        #1;
        check("async_reset_mid_travel", 1'b0, 1'b0);
        RST = 1'b0;
        #1;
        check("idle_after_async_reset", 1'b0, 1'b0);
        tick();
        check("idle_after_reset_edge", 1'b0, 1'b0);

        drive(1'b1, 1'b1, 1'b0);
        check("idle_at_top_request", 1'b0, 1'b1);
        tick();
        drive(1'b1, 1'b0, 1'b1);
        check("bottom_limit_stops_same_cycle", 1'b0, 1'b0);
        tick();
        check("idle_at_bottom_reopens", 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
